// File: rtl/regfile_scoreboard.sv
// Architectural register file with W-to-D bypass and a per-register scoreboard
// of in-flight writes that stalls decode on unready sources or a saturated destination.
module regfile_scoreboard #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned NREG  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  input  logic [4:0]  A1D,
  input  logic [4:0]  A2D,
  input  logic        Use1D,
  input  logic        Use2D,
  input  logic        IssueD,
  input  logic        DstValidD,
  input  logic [4:0]  DstRegD,
  input  logic        FlushE,
  input  logic        FlushDstValidE,
  input  logic [4:0]  FlushDstE,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic        StallD,
  output logic [31:0] BusyVec,
  output logic [6:0]  InFlight,
  output logic        ScbErr
);

  localparam int unsigned AW = 5;
  localparam int unsigned SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MaxC = '1;

  logic [31:0]                 regs_q [NREG];
  logic [31:0]                 regs_d [NREG];
  logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic [6:0]                  inflight_q, inflight_d;
  logic                        err_q, err_d;
  logic [NREG-1:0]             ready;
  logic                        issue_ok;

  // Read ports: r0 is hardwired, a same-cycle writeback wins over the array.
  always_comb begin
    RD1D = '0;
    if (A1D != '0) begin
      if (RegWriteW && WriteRegW == A1D) RD1D = ResultW;
      else                               RD1D = regs_q[A1D];
    end
  end

  always_comb begin
    RD2D = '0;
    if (A2D != '0) begin
      if (RegWriteW && WriteRegW == A2D) RD2D = ResultW;
      else                               RD2D = regs_q[A2D];
    end
  end

  // The last outstanding write completing now is ready thanks to the bypass.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      ready[r] = (r == 0) || (cnt_q[r] == '0) ||
                 ((cnt_q[r] == CNT_W'(1)) && RegWriteW && (WriteRegW == AW'(r)));
    end
  end

  always_comb begin
    StallD = IssueD && ((Use1D && !ready[A1D]) ||
                        (Use2D && !ready[A2D]) ||
                        (DstValidD && (DstRegD != '0) && (cnt_q[DstRegD] == MaxC)));
  end

  assign issue_ok = IssueD && !StallD;

  always_comb begin : cnt_next
    logic signed [SW-1:0] nxt;
    logic                 inc;
    logic                 dec_w;
    logic                 dec_f;
    nxt        = '0;
    inc        = 1'b0;
    dec_w      = 1'b0;
    dec_f      = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;
    busy_d     = '0;
    inflight_d = '0;
    cnt_d[0]   = '0;
    for (int r = 1; r < NREG; r++) begin
      inc   = issue_ok && DstValidD && (DstRegD == AW'(r));
      dec_w = RegWriteW && (WriteRegW == AW'(r));
      dec_f = FlushE && FlushDstValidE && (FlushDstE == AW'(r));
      nxt   = SW'(cnt_q[r]) + SW'(inc) - SW'(dec_w) - SW'(dec_f);
      if (nxt[SW-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (|nxt[SW-2:CNT_W]) begin
        cnt_d[r] = MaxC;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = nxt[CNT_W-1:0];
      end
    end
    for (int r = 0; r < NREG; r++) begin
      busy_d[r]  = |cnt_d[r];
      inflight_d = inflight_d + 7'(cnt_d[r]);
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (RegWriteW && WriteRegW != '0) regs_d[WriteRegW] = ResultW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q     <= '{default: '0};
      cnt_q      <= '0;
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign BusyVec  = busy_q;
  assign InFlight = inflight_q;
  assign ScbErr   = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a cycle-level
// model of register contents and per-register outstanding-write counts.
module tb_regfile_scoreboard;

  logic        clk, rst;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [4:0]  A1D, A2D;
  logic        Use1D, Use2D, IssueD, DstValidD;
  logic [4:0]  DstRegD;
  logic        FlushE, FlushDstValidE;
  logic [4:0]  FlushDstE;
  logic [31:0] RD1D, RD2D;
  logic        StallD;
  logic [31:0] BusyVec;
  logic [6:0]  InFlight;
  logic        ScbErr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  regfile_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .RegWriteW      (RegWriteW),
    .WriteRegW      (WriteRegW),
    .ResultW        (ResultW),
    .A1D            (A1D),
    .A2D            (A2D),
    .Use1D          (Use1D),
    .Use2D          (Use2D),
    .IssueD         (IssueD),
    .DstValidD      (DstValidD),
    .DstRegD        (DstRegD),
    .FlushE         (FlushE),
    .FlushDstValidE (FlushDstValidE),
    .FlushDstE      (FlushDstE),
    .RD1D           (RD1D),
    .RD2D           (RD2D),
    .StallD         (StallD),
    .BusyVec        (BusyVec),
    .InFlight       (InFlight),
    .ScbErr         (ScbErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit m_ready(input logic [4:0] a);
    return (a == 0) || (m_cnt[a] == 0) || (m_cnt[a] == 1 && RegWriteW && WriteRegW == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return m_regs[a];
  endfunction

  function automatic bit m_stall();
    return IssueD && ((Use1D && !m_ready(A1D)) || (Use2D && !m_ready(A2D)) ||
                      (DstValidD && DstRegD != 0 && m_cnt[DstRegD] == 3));
  endfunction

  task automatic idle();
    RegWriteW = 0; WriteRegW = 0; ResultW = 0;
    A1D = 0; A2D = 0; Use1D = 0; Use2D = 0;
    IssueD = 0; DstValidD = 0; DstRegD = 0;
    FlushE = 0; FlushDstValidE = 0; FlushDstE = 0;
  endtask

  task automatic issue(input logic [4:0] d);
    IssueD = 1; DstValidD = 1; DstRegD = d;
  endtask

  // Checks every output against the model mid-cycle, then advances the model.
  task automatic cycle();
    logic [31:0] exp_busy;
    int          exp_sum;
    bit          stall, ok;
    int          n;
    int          nxt_cnt [32];
    @(negedge clk);
    stall    = m_stall();
    exp_busy = '0;
    exp_sum  = 0;
    for (int r = 0; r < 32; r++) begin
      exp_busy[r] = (m_cnt[r] != 0);
      exp_sum     = exp_sum + m_cnt[r];
    end
    check_eq("rd1", RD1D, m_read(A1D));
    check_eq("rd2", RD2D, m_read(A2D));
    check_eq("stall", 32'(StallD), 32'(stall));
    check_eq("busy", BusyVec, exp_busy);
    check_eq("inflight", 32'(InFlight), 32'(exp_sum));
    check_eq("err", 32'(ScbErr), 32'(m_err));
    ok = IssueD && !stall;
    for (int r = 0; r < 32; r++) begin
      n = m_cnt[r];
      if (r != 0) begin
        if (ok && DstValidD && DstRegD == r) n++;
        if (RegWriteW && WriteRegW == r) n--;
        if (FlushE && FlushDstValidE && FlushDstE == r) n--;
        if (n < 0) begin n = 0; m_err = 1'b1; end
        if (n > 3) begin n = 3; m_err = 1'b1; end
      end
      nxt_cnt[r] = n;
    end
    @(posedge clk);
    #1;
    if (RegWriteW && WriteRegW != 0) m_regs[WriteRegW] = ResultW;
    for (int r = 0; r < 32; r++) m_cnt[r] = nxt_cnt[r];
  endtask

  // Asynchronous reset pulse between edges; optionally checks immediate clearing.
  task automatic async_reset(input bit chk);
    rst = 1'b0;
    #1;
    if (chk) begin
      check_eq("arst_err", 32'(ScbErr), 32'd0);
      check_eq("arst_busy", BusyVec, 32'd0);
      check_eq("arst_inflight", 32'(InFlight), 32'd0);
    end
    model_reset();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset then read
    A1D = 5; A2D = 0;
    #1;
    check_eq("rst_rd1", RD1D, 32'd0);
    check_eq("rst_stall", 32'(StallD), 32'd0);
    cycle();

    // Write with same-cycle bypass, then plain read, then r0 write
    idle();
    RegWriteW = 1; WriteRegW = 7; ResultW = 32'hDEADBEEF; A2D = 7;
    #1;
    check_eq("bypass_rd2", RD2D, 32'hDEADBEEF);
    cycle();
    idle();
    A1D = 7;
    #1;
    check_eq("read_rd1", RD1D, 32'hDEADBEEF);
    cycle();
    idle();
    RegWriteW = 1; WriteRegW = 0; ResultW = 32'h1234; A1D = 0;
    cycle();
    idle();
    cycle();

    // RAW stall resolved by writeback bypass
    async_reset(1'b0);
    idle(); issue(3);
    cycle();
    idle(); IssueD = 1; Use1D = 1; A1D = 3;
    #1;
    check_eq("raw_stall", 32'(StallD), 32'd1);
    check_eq("raw_busy3", 32'(BusyVec[3]), 32'd1);
    check_eq("raw_inflight", 32'(InFlight), 32'd1);
    cycle();
    RegWriteW = 1; WriteRegW = 3; ResultW = 42;
    #1;
    check_eq("raw_release", 32'(StallD), 32'd0);
    check_eq("raw_rd1", RD1D, 32'd42);
    cycle();
    idle();
    cycle();
    check_eq("raw_busy3_clr", 32'(BusyVec[3]), 32'd0);

    // Saturation at three outstanding writes
    async_reset(1'b0);
    idle(); issue(9);
    repeat (3) cycle();
    #1;
    check_eq("sat_stall", 32'(StallD), 32'd1);
    check_eq("sat_inflight", 32'(InFlight), 32'd3);
    cycle();
    RegWriteW = 1; WriteRegW = 9; ResultW = 32'h99;
    cycle();
    RegWriteW = 0;
    #1;
    check_eq("sat_accept", 32'(StallD), 32'd0);
    check_eq("sat_inflight2", 32'(InFlight), 32'd2);
    cycle();
    idle();
    cycle();

    // Flush and simultaneous issue/writeback
    async_reset(1'b0);
    idle(); issue(4);
    cycle();
    idle(); FlushE = 1; FlushDstValidE = 1; FlushDstE = 4;
    cycle();
    idle();
    #1;
    check_eq("flush_busy4", 32'(BusyVec[4]), 32'd0);
    check_eq("flush_err", 32'(ScbErr), 32'd0);
    issue(4);
    cycle();
    issue(4); RegWriteW = 1; WriteRegW = 4; ResultW = 32'h44;
    cycle();
    idle();
    #1;
    check_eq("net0_inflight", 32'(InFlight), 32'd1);

    // Underflow: data still written, error sticky, async reset clears
    RegWriteW = 1; WriteRegW = 12; ResultW = 32'h12345678;
    cycle();
    idle(); A1D = 12;
    #1;
    check_eq("uf_rd1", RD1D, 32'h12345678);
    check_eq("uf_err", 32'(ScbErr), 32'd1);
    cycle();
    cycle();
    check_eq("uf_sticky", 32'(ScbErr), 32'd1);
    async_reset(1'b1);

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) async_reset(1'b1);
      RegWriteW      = ($urandom_range(0, 3) == 0);
      WriteRegW      = 5'($urandom_range(0, 7));
      ResultW        = $urandom;
      A1D            = 5'($urandom_range(0, 7));
      A2D            = 5'($urandom_range(0, 7));
      Use1D          = 1'($urandom);
      Use2D          = 1'($urandom);
      IssueD         = ($urandom_range(0, 3) != 0);
      DstValidD      = ($urandom_range(0, 3) != 0);
      DstRegD        = 5'($urandom_range(0, 7));
      FlushE         = ($urandom_range(0, 7) == 0);
      FlushDstValidE = 1'($urandom);
      FlushDstE      = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
